// File: rtl/msg_sched_pkg.sv
// Shared types and defaults for the message byte scheduler.
// Optional terminator forwarding is selected by MSG_SCHED_FWD_TERM_EN.
package msg_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EMIT_LO,
    EMIT_HI,
    CLOSE,
    COOLDOWN
  } state_t;

  localparam logic [7:0] TERM_BYTE = 8'h00;

  localparam int MAX_BYTES_DEF = 64;
  localparam int COOLDOWN_DEF  = 16;
  localparam int CNT_W_DEF     = 8;

  function automatic logic [7:0] sel_byte(
    input logic [15:0] w,
    input logic        hi
  );
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/msg_cooldown_timer.sv
// Hold-off counter: start loads 1, counts up to CYCLES, pulses done once.
// Reusable by any controller needing a fixed idle window.
module msg_cooldown_timer
  import msg_sched_pkg::*;
#(
  parameter int CYCLES = COOLDOWN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;
  logic         active;

  assign done = active && (cnt == W'(CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= W'(1);
      active <= 1'b1;
    end else if (done) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (active) begin
      cnt    <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/msg_byte_scheduler.sv
// Splits 16-bit message words into bytes, closes on terminator or length.
// MSG_SCHED_FWD_TERM_EN forwards the 0x00 terminator as a visible byte.
module msg_byte_scheduler
  import msg_sched_pkg::*;
#(
  parameter int MAX_BYTES       = MAX_BYTES_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             busy,
  output logic             msg_done,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_count
);

`ifdef MSG_SCHED_FWD_TERM_EN
  localparam bit FWD_TERM = 1'b1;
`else
  localparam bit FWD_TERM = 1'b0;
`endif

  state_t           state, state_n;
  logic [15:0]      word;
  logic             busy_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt;

  logic             ld, inc, ovf_set;
  logic             tm_start, tm_done;
  logic [7:0]       cur;
  logic             is_term, at_max;

  assign cur     = sel_byte(word, state == EMIT_HI);
  assign is_term = (cur == TERM_BYTE);
  assign at_max  = (cnt + CNT_W'(1)) == CNT_W'(MAX_BYTES);

  msg_cooldown_timer #(
    .CYCLES(COOLDOWN_CYCLES)
  ) u_cool (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tm_start),
    .done (tm_done)
  );

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    ld        = 1'b0;
    inc       = 1'b0;
    ovf_set   = 1'b0;
    tm_start  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld      = 1'b1;
          state_n = EMIT_LO;
        end
      end
      EMIT_LO, EMIT_HI: begin
        if (is_term && !FWD_TERM) begin
          state_n = CLOSE;
        end else begin
          out_valid = 1'b1;
          out_byte  = cur;
          if (out_ready) begin
            if (is_term) begin
              state_n = CLOSE;
            end else begin
              inc = 1'b1;
              if (at_max) begin
                state_n = CLOSE;
                ovf_set = 1'b1;
              end else if (state == EMIT_LO) begin
                // a suppressed high terminator is skipped, not shown
                if (!FWD_TERM && word[15:8] == TERM_BYTE)
                  state_n = CLOSE;
                else
                  state_n = EMIT_HI;
              end else begin
                in_ready = 1'b1;
                if (in_valid) begin
                  ld      = 1'b1;
                  state_n = EMIT_LO;
                end else begin
                  state_n = IDLE;
                end
              end
            end
          end
        end
      end
      CLOSE: begin
        tm_start = 1'b1;
        state_n  = COOLDOWN;
      end
      COOLDOWN: begin
        if (tm_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      word   <= '0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      ovf_r <= ovf_set;
      if (ld) word <= in_word;
      if (ld && !busy_r)
        busy_r <= 1'b1;
      else if (state == COOLDOWN && tm_done)
        busy_r <= 1'b0;
      if (ld && !busy_r)
        cnt <= '0;
      else if (inc)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign busy       = busy_r;
  assign msg_done   = (state == CLOSE);
  assign overflow   = (state == CLOSE) && ovf_r;
  assign byte_count = cnt;

endmodule

// File: tb/tb_msg_byte_scheduler.sv
// Randomized bench for msg_byte_scheduler against a byte-list reference.
// Honors MSG_SCHED_FWD_TERM_EN when building the expected byte stream.
module tb_msg_byte_scheduler;

  localparam int MAXB = 12;
  localparam int CDN  = 16;
  localparam int CW   = 8;

`ifdef MSG_SCHED_FWD_TERM_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_word;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          busy;
  logic          msg_done;
  logic          overflow;
  logic [CW-1:0] byte_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] wq[$];
  logic [7:0]  exp_q[$];
  bit          exp_ovf;
  int          exp_nw;
  int          exp_cnt;

  msg_byte_scheduler #(
    .MAX_BYTES      (MAXB),
    .COOLDOWN_CYCLES(CDN),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .busy      (busy),
    .msg_done  (msg_done),
    .overflow  (overflow),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk the bytes low-first; stop at terminator or MAXB data bytes.
  task automatic model();
    int c;
    logic [7:0] b;
    c = 0;
    exp_q.delete();
    exp_ovf = 0;
    exp_nw  = -1;
    exp_cnt = 0;
    for (int i = 0; i < wq.size(); i++) begin
      for (int k = 0; k < 2; k++) begin
        b = (k == 0) ? wq[i][7:0] : wq[i][15:8];
        if (b == 8'h00) begin
          if (FWD) exp_q.push_back(b);
          exp_nw  = i + 1;
          exp_cnt = c;
          return;
        end
        exp_q.push_back(b);
        c++;
        if (c == MAXB) begin
          exp_ovf = 1;
          exp_nw  = i + 1;
          exp_cnt = c;
          return;
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_byte"}, 32'(out_byte), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_msg_done"}, 32'(msg_done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
  endtask

  task automatic run_msg(input bit rnd_iv, input bit rnd_or,
                         input bit lat, input bit want_bb);
    logic [7:0] got[$];
    int n_acc, t, last_x, acc_c, done_c, bb, k;
    bit done, stall, busy_d, first;
    logic [7:0] stall_b;
    logic got_ovf;
    logic [CW-1:0] got_cnt;
    n_acc = 0; t = 0; last_x = -1; acc_c = -1; done_c = -1; bb = 0;
    done = 0; stall = 0; stall_b = 8'h00; busy_d = 0;
    got_ovf = 0; got_cnt = '0;
    model();
    @(posedge clk); #1;
    while (!done && t < 2000) begin
      in_valid  = (n_acc < exp_nw) && (!rnd_iv || $urandom_range(0, 3) != 0);
      in_word   = (n_acc < exp_nw) ? wq[n_acc] : 16'h0000;
      out_ready = !rnd_or || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_byte", 32'(out_byte), 32'(stall_b));
      end
      stall   = out_valid && !out_ready;
      stall_b = out_byte;
      if (out_valid && out_ready) begin
        got.push_back(out_byte);
        last_x = cyc;
      end
      if (in_valid && in_ready) begin
        n_acc++;
        acc_c = cyc;
        if (out_valid && out_ready) bb++;
      end
      if (msg_done) begin
        done    = 1;
        done_c  = cyc;
        got_ovf = overflow;
        got_cnt = byte_count;
        busy_d  = busy;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("msg_done_seen", 32'(done), 32'd1);
    chk("nbytes", 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got.size()) chk("byte", 32'(got[i]), 32'(exp_q[i]));
    chk("overflow", 32'(got_ovf), 32'(exp_ovf));
    chk("byte_count", 32'(got_cnt), 32'(exp_cnt));
    chk("words_used", 32'(n_acc), 32'(exp_nw));
    chk("busy_in_msg", 32'(busy_d), 32'd1);
    if (lat) begin
      if (got.size() > 0) chk("close_lat", 32'(done_c - last_x), 32'd1);
      else chk("close_lat0", 32'(done_c - acc_c), 32'd2);
    end
    if (want_bb) chk("b2b_load", 32'(bb > 0), 32'd1);
    k = 0;
    first = 1;
    while (k < CDN + 8) begin
      @(negedge clk);
      if (first) chk("done_pulse", 32'(msg_done), 32'd0);
      first = 0;
      if (in_ready) break;
      k++;
    end
    chk("cooldown_len", 32'(k), 32'(CDN));
    chk("busy_clear", 32'(busy), 32'd0);
    chk("count_hold", 32'(byte_count), 32'(exp_cnt));
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_word   = 16'h0000;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wq = {16'h4241, 16'h0043};
    run_msg(1'b0, 1'b0, 1'b1, 1'b1);

    wq = {16'h7700};
    run_msg(1'b0, 1'b0, 1'b1, 1'b0);

    wq = {16'h0201, 16'h0403, 16'h0605, 16'h0807,
          16'h0a09, 16'h0c0b, 16'h0e0d};
    run_msg(1'b0, 1'b0, 1'b1, 1'b0);

    wq = {16'h0201, 16'h0403, 16'h0605, 16'h0807,
          16'h0a09, 16'h0000};
    run_msg(1'b0, 1'b1, 1'b0, 1'b1);

    in_valid  = 1'b1;
    in_word   = 16'h4241;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_byte", 32'(out_byte), 32'h42);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(msg_done), 32'd0);
    end
    #2 rst_n = 1'b1;
    wq = {16'h5251, 16'h0053};
    run_msg(1'b0, 1'b0, 1'b1, 1'b1);

    for (int m = 0; m < 25; m++) begin
      wq.delete();
      for (int i = 0; i < 7; i++) begin
        logic [7:0] lo, hi;
        lo = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        hi = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        wq.push_back({hi, lo});
      end
      run_msg(1'b1, 1'b1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msg_byte_scheduler.md
Name: msg_byte_scheduler

Overview:
- Sequences message words into the byte-wide crypto datapath.
- Accepts 16-bit words over a valid/ready handshake and emits bytes low-byte-first over a second valid/ready handshake.
- Detects the 0x00 terminator byte or a length limit to close a message.
- After each message, enforces a programmable cooldown window before the next message may start.

Parameters:
- MAX_BYTES, 64, maximum data bytes per message (terminator excluded); reaching it closes the message with overflow.
- COOLDOWN_CYCLES, 16, idle cycles after msg_done before in_ready may reassert; legal range 1..2^28-1.
- CNT_W, 8, width of byte_count; must hold MAX_BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_word valid
- in_ready  out  1  scheduler can take a word
- in_word  in  16  message word; [7:0] sent first, then [15:8]
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte
- out_byte  out  8  byte to datapath
- busy  out  1  high from first word accepted until cooldown expires
- msg_done  out  1  one-cycle pulse on message close
- overflow  out  1  one-cycle pulse, coincident with msg_done, when MAX_BYTES ended the message
- byte_count  out  CNT_W  data bytes forwarded in the current or last message

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: state IDLE; in_ready=1; out_valid=0; out_byte=0; busy=0; msg_done=0; overflow=0; byte_count=0; word register and cooldown counter cleared.
  - Reset mid-message discards the held word and the remainder of the message.
  - No msg_done is issued for the discarded message.
- States: IDLE, EMIT_LO, EMIT_HI, CLOSE, COOLDOWN.
- IDLE / word load:
  - in_ready=1 only in IDLE, and in EMIT_HI in the cycle the high byte transfers (back-to-back load).
  - On in_valid&&in_ready the word is registered.
  - Next state is EMIT_LO; out_valid rises the following cycle (1-cycle latency).
  - busy sets on the first word of a message; byte_count clears on that first word.
- EMIT_LO / EMIT_HI:
  - out_valid=1. out_byte = word[7:0] in EMIT_LO, word[15:8] in EMIT_HI.
  - A transfer occurs on out_valid&&out_ready.
  - out_byte and out_valid hold stable while out_ready=0.
- Terminator:
  - A byte equal to 0x00 closes the message and goes to CLOSE.
  - In EMIT_LO the high byte of that word is discarded.
  - Without MSG_SCHED_FWD_TERM_EN the terminator is not presented on out_valid; the check is made on the registered byte, and the state moves straight to CLOSE.
  - The terminator is not counted in byte_count.
- Length limit: when a non-zero byte transfers and byte_count reaches MAX_BYTES, go to CLOSE with overflow; remaining bytes of the word are discarded.
- After a non-terminating EMIT_HI transfer:
  - If in_valid is high in the same cycle, load the next word and go to EMIT_LO.
  - Otherwise go to IDLE with busy held at 1 (mid-message).
- CLOSE: single cycle; msg_done=1, overflow as applicable; byte_count frozen; go to COOLDOWN.
- COOLDOWN:
  - in_ready=0; counter counts 1..COOLDOWN_CYCLES, then state goes to IDLE and busy clears.
  - byte_count holds until the next message's first word.
- Simultaneity: terminator and MAX_BYTES are evaluated on distinct bytes. If the byte after the MAX_BYTES-th is not needed, overflow takes priority at the MAX_BYTES-th transfer.

Optional Feature:
- Macro: MSG_SCHED_FWD_TERM_EN.
- Defined: the 0x00 terminator is presented as a normal byte (out_valid, waits for out_ready). CLOSE follows its transfer. byte_count still excludes it.
- Undefined: the terminator is consumed internally and never appears on out_byte.

Decomposition:
- Package msg_sched_pkg holds:
  - the state enum (IDLE, EMIT_LO, EMIT_HI, CLOSE, COOLDOWN);
  - the TERM_BYTE=8'h00 constant;
  - the default constants for MAX_BYTES and COOLDOWN_CYCLES.
- Sub-module msg_cooldown_timer: load/start input, done output, width = clog2(COOLDOWN_CYCLES+1). Mirrors the existing hold-off counter style, reusable by other controllers.

Test Plan:
- Words 0x4241, 0x0043, out_ready=1:
  - out_byte sequence 0x41, 0x42, 0x43;
  - msg_done pulse one cycle after 0x43 (terminator suppressed), byte_count=3, overflow=0;
  - in_ready low for exactly 16 cycles after CLOSE.
- Same stimulus with MSG_SCHED_FWD_TERM_EN: bytes 0x41, 0x42, 0x43, 0x00; byte_count=3.
- Word 0x7700: no bytes output; msg_done next cycle; byte_count=0; 0x77 discarded.
- MAX_BYTES=4, words 0x0201, 0x0403, 0x0605: bytes 0x01..0x04, then msg_done and overflow together; 0x05/0x06 never appear.
- out_ready toggled 0/1 pseudo-randomly over a 10-byte message: each byte stays stable under stall; no byte duplicated or dropped; back-to-back word load is observed in an EMIT_HI transfer cycle.
- rst_n pulsed low mid-EMIT_HI: all outputs go to reset values asynchronously, with no msg_done. A new message after release is forwarded correctly from its first byte.
